// File: rtl/spm_mem_arbiter_if.sv
// +-----------------------------------------------------------------------+
// | spm_mem_arbiter_if : requester-side bus of the RISC_SPM memory arbiter |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

interface spm_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/spm_mem_arbiter.sv
// +-----------------------------------------------------------------------+
// | spm_mem_arbiter : 3-port round-robin arbiter for the 256x8 SPM memory  |
// | Rev 1.0 -- SPM_ARB_FIXED_PRIO_EN selects fixed priority 1 > 2 > 0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module spm_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spm_mem_arbiter_if.slave      bus,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_win;
  logic          r_en;
  logic          r_we;
  logic [2:0]    r_gnt;
  logic [2:0]    r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    w_win;
  logic          w_any;

`ifdef SPM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any = |bus.req;
    w_win = 2'd0;
    if (bus.req[1])
      w_win = 2'd1;
    else if (bus.req[2])
      w_win = 2'd2;
  end
`else
  logic [1:0] r_ptr;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Search last+1, last+2, then last itself (last+3 mod 3).
  always_comb begin
    w_any = |bus.req;
    w_c1  = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    if (bus.req[w_c1])
      w_win = w_c1;
    else if (bus.req[w_c2])
      w_win = w_c2;
    else
      w_win = r_ptr;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_win     <= 2'd0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_gnt     <= 3'b000;
      r_rvalid  <= 3'b000;
      r_rdata   <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifndef SPM_ARB_FIXED_PRIO_EN
      r_ptr     <= 2'd2;
`endif
    end else begin
      r_gnt    <= 3'b000;
      r_rvalid <= 3'b000;
      r_en     <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= ISSUE;
            r_win     <= w_win;
            r_gnt     <= 3'b001 << w_win;
            r_en      <= 1'b1;
            r_we      <= bus.we[w_win];
            mem_addr  <= bus.addr[w_win*AW +: AW];
            mem_wdata <= bus.wdata[w_win*DW +: DW];
            busy      <= 1'b1;
`ifndef SPM_ARB_FIXED_PRIO_EN
            r_ptr     <= w_win;
`endif
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_rdata  <= mem_rdata;
          r_rvalid <= 3'b001 << r_win;
          r_state  <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are masked by rst so a reset landing in ISSUE never reaches the macro.
  assign mem_en     = r_en & ~rst;
  assign mem_we     = r_we & ~rst;
  assign bus.gnt    = r_gnt & {3{~rst}};
  assign bus.rvalid = r_rvalid & {3{~rst}};
  assign bus.rdata  = r_rdata;

endmodule

`default_nettype wire
